// File: rtl/calculator_top.sv
// 16-bit signed four-function keypad calculator: keypad scan/debounce/decode plus operand/operator sequencer.
// Optional macro DIVIDE_KEY_EN enables key 15 as signed divide; otherwise key 15 is acknowledged and ignored.

module input_ctrl #(
  parameter int unsigned SCAN_DWELL      = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       nRST,
  input  logic [3:0] RowIn,
  output logic [3:0] ColOut,
  output logic       o_key_valid,
  output logic [3:0] o_key
);
  localparam int unsigned DW = $clog2(SCAN_DWELL + 1);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {SCAN = 2'd0, DEBOUNCE = 2'd1, DECODE = 2'd2, HOLD = 2'd3} state_t;

  state_t        state;
  logic [DW-1:0] r_dwell;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_row;
  logic [1:0]    w_col_idx;
  logic [1:0]    w_row_idx;

  always_comb begin
    w_col_idx = 2'd0;
    unique case (ColOut)
      4'b1101: w_col_idx = 2'd1;
      4'b1011: w_col_idx = 2'd2;
      4'b0111: w_col_idx = 2'd3;
      default: w_col_idx = 2'd0;
    endcase
  end

  // Lowest-numbered active row wins when several rows read low.
  always_comb begin
    w_row_idx = 2'd3;
    if      (!r_row[0]) w_row_idx = 2'd0;
    else if (!r_row[1]) w_row_idx = 2'd1;
    else if (!r_row[2]) w_row_idx = 2'd2;
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state       <= SCAN;
      ColOut      <= 4'b1110;
      r_dwell     <= '0;
      r_cnt       <= '0;
      r_row       <= '1;
      o_key_valid <= 1'b0;
      o_key       <= '0;
    end else begin
      unique case (state)
        SCAN: begin
          if (RowIn != 4'b1111) begin
            r_row <= RowIn;
            r_cnt <= '0;
            state <= DEBOUNCE;
          end else if (r_dwell == DW'(SCAN_DWELL - 1)) begin
            r_dwell <= '0;
            ColOut  <= {ColOut[2:0], ColOut[3]};
          end else begin
            r_dwell <= r_dwell + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (RowIn == 4'b1111 || RowIn != r_row) begin
            r_dwell <= '0;
            state   <= SCAN;
          end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            state <= DECODE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DECODE: begin
          o_key       <= {w_row_idx, w_col_idx};
          o_key_valid <= 1'b1;
          r_cnt       <= '0;
          state       <= HOLD;
        end
        HOLD: begin
          if (RowIn == 4'b1111) begin
            if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
              o_key_valid <= 1'b0;
              r_dwell     <= '0;
              state       <= SCAN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_cnt <= '0;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end
endmodule

module gencon (
  input  logic        clk,
  input  logic        nRST,
  input  logic        i_key_valid,
  input  logic [3:0]  i_key,
  output logic [15:0] o_display,
  output logic        o_complete
);
  typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  logic        key_read;
  logic [15:0] r_a;
  logic [15:0] r_b;
  op_t         r_op;
  logic        r_on_b;
  logic        r_b_ent;

  logic        w_is_digit;
  logic [3:0]  w_digit;
  logic        w_is_op;
  op_t         w_new_op;
  logic [15:0] w_alu;
  logic [15:0] w_a_next;
  logic [15:0] w_b_next;

  always_comb begin
    w_is_digit = 1'b0;
    w_digit    = 4'd0;
    w_is_op    = 1'b0;
    w_new_op   = OP_NONE;
    if (i_key == 4'd13) begin
      w_is_digit = 1'b1;
    end else if (i_key[3:2] != 2'd3 && i_key[1:0] != 2'd3) begin
      w_is_digit = 1'b1;
      w_digit    = 4'(i_key[3:2] * 2'd3) + 4'(i_key[1:0]) + 4'd1;
    end
    unique case (i_key)
      4'd3:  begin w_is_op = 1'b1; w_new_op = OP_ADD; end
      4'd7:  begin w_is_op = 1'b1; w_new_op = OP_SUB; end
      4'd11: begin w_is_op = 1'b1; w_new_op = OP_MUL; end
`ifdef DIVIDE_KEY_EN
      4'd15: begin w_is_op = 1'b1; w_new_op = OP_DIV; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    w_a_next = r_a * 16'd10 + {12'd0, w_digit};
    w_b_next = r_b * 16'd10 + {12'd0, w_digit};
    unique case (r_op)
      OP_ADD:  w_alu = r_a + r_b;
      OP_SUB:  w_alu = r_a - r_b;
      OP_MUL:  w_alu = r_a * r_b;
`ifdef DIVIDE_KEY_EN
      OP_DIV:  w_alu = (r_b == '0) ? '0 : 16'($signed(r_a) / $signed(r_b));
`endif
      default: w_alu = r_a;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      key_read   <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= OP_NONE;
      r_on_b     <= 1'b0;
      r_b_ent    <= 1'b0;
      o_display  <= '0;
      o_complete <= 1'b0;
    end else if (!i_key_valid) begin
      key_read <= 1'b0;
    end else if (!key_read) begin
      key_read <= 1'b1;
      if (w_is_digit) begin
        if (o_complete) begin
          r_a        <= {12'd0, w_digit};
          r_b        <= '0;
          r_op       <= OP_NONE;
          r_on_b     <= 1'b0;
          r_b_ent    <= 1'b0;
          o_complete <= 1'b0;
          o_display  <= {12'd0, w_digit};
        end else if (r_on_b) begin
          r_b       <= w_b_next;
          r_b_ent   <= 1'b1;
          o_display <= w_b_next;
        end else begin
          r_a       <= w_a_next;
          o_display <= w_a_next;
        end
      end else if (w_is_op) begin
        // After equals the result already lives in A, so only chaining needs evaluation.
        if (o_complete) begin
          o_complete <= 1'b0;
        end else if (r_b_ent && r_op != OP_NONE) begin
          r_a       <= w_alu;
          o_display <= w_alu;
        end
        r_op    <= w_new_op;
        r_b     <= '0;
        r_on_b  <= 1'b1;
        r_b_ent <= 1'b0;
      end else if (i_key == 4'd12) begin
        if (!o_complete) begin
          r_a        <= w_alu;
          o_display  <= w_alu;
          o_complete <= 1'b1;
        end
      end else if (i_key == 4'd14) begin
        r_a        <= '0;
        r_b        <= '0;
        r_op       <= OP_NONE;
        r_on_b     <= 1'b0;
        r_b_ent    <= 1'b0;
        o_display  <= '0;
        o_complete <= 1'b0;
      end
    end
  end
endmodule

module calculator_top #(
  parameter int unsigned SCAN_DWELL      = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [3:0]  RowIn,
  output logic [3:0]  ColOut,
  output logic [15:0] display_output,
  output logic        complete
);
  logic       w_key_valid;
  logic [3:0] w_key;

  input_ctrl #(
    .SCAN_DWELL      (SCAN_DWELL),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) input_ctrl_inst (
    .clk         (clk),
    .nRST        (nRST),
    .RowIn       (RowIn),
    .ColOut      (ColOut),
    .o_key_valid (w_key_valid),
    .o_key       (w_key)
  );

  gencon gencon_inst (
    .clk         (clk),
    .nRST        (nRST),
    .i_key_valid (w_key_valid),
    .i_key       (w_key),
    .o_display   (display_output),
    .o_complete  (complete)
  );
endmodule

// File: tb/tb_calculator_top.sv
// Randomized self-checking bench for calculator_top: a keypad model drives RowIn from ColOut,
// and a reference calculator computes expected display/complete after every key.

module tb_calculator_top;
  logic        clk = 1'b0;
  logic        nRST;
  logic [3:0]  RowIn;
  logic [3:0]  ColOut;
  logic [15:0] display_output;
  logic        complete;

  int  n_tests = 0;
  int  n_fail  = 0;

  bit  pressing = 1'b0;
  bit  glitch   = 1'b0;
  int  key_row  = 0;
  int  key_col  = 0;

  // Reference calculator state.
  int  m_a, m_b, m_op, m_disp;
  bit  m_onb, m_bent, m_comp;

  calculator_top #(
    .SCAN_DWELL      (16),
    .DEBOUNCE_CYCLES (2)
  ) dut (
    .clk            (clk),
    .nRST           (nRST),
    .RowIn          (RowIn),
    .ColOut         (ColOut),
    .display_output (display_output),
    .complete       (complete)
  );

  always #5 clk = ~clk;

  always_comb begin
    RowIn = 4'b1111;
    if (glitch) RowIn = 4'b1110;
    else if (pressing && ColOut[key_col] == 1'b0) RowIn[key_row] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int alu16(input int a, input int b, input int op);
    shortint sa, sb;
    int r;
    sa = shortint'(a);
    sb = shortint'(b);
    case (op)
      1: r = int'(sa) + int'(sb);
      2: r = int'(sa) - int'(sb);
      3: r = int'(sa) * int'(sb);
      4: r = (sb == 0) ? 0 : int'(sa) / int'(sb);
      default: r = int'(sa);
    endcase
    return r & 32'hFFFF;
  endfunction

  function automatic void model_reset();
    m_a = 0; m_b = 0; m_op = 0; m_disp = 0;
    m_onb = 0; m_bent = 0; m_comp = 0;
  endfunction

  function automatic void model_key(input int k);
    int digit, opk;
    digit = -1;
    opk   = 0;
    if (k == 13) digit = 0;
    else if (k / 4 < 3 && k % 4 < 3) digit = (k / 4) * 3 + (k % 4) + 1;
    if (k == 3) opk = 1;
    if (k == 7) opk = 2;
    if (k == 11) opk = 3;
`ifdef DIVIDE_KEY_EN
    if (k == 15) opk = 4;
`endif
    if (digit >= 0) begin
      if (m_comp) begin
        model_reset();
        m_a = digit; m_disp = digit;
      end else if (m_onb) begin
        m_b = (m_b * 10 + digit) & 32'hFFFF; m_bent = 1; m_disp = m_b;
      end else begin
        m_a = (m_a * 10 + digit) & 32'hFFFF; m_disp = m_a;
      end
    end else if (opk != 0) begin
      if (m_comp) m_comp = 0;
      else if (m_bent && m_op != 0) begin
        m_a = alu16(m_a, m_b, m_op); m_disp = m_a;
      end
      m_op = opk; m_b = 0; m_onb = 1; m_bent = 0;
    end else if (k == 12) begin
      if (!m_comp) begin
        m_a = alu16(m_a, m_b, m_op); m_disp = m_a; m_comp = 1;
      end
    end else if (k == 14) begin
      model_reset();
    end
  endfunction

  task automatic press(input int k, input int hold_cycles);
    int n;
    int lows;
    @(negedge clk);
    key_row = k / 4; key_col = k % 4; pressing = 1'b1;
    n = 0;
    while (!dut.gencon_inst.key_read && n < 400) begin
      @(negedge clk); n++;
    end
    check("key_ack", 32'(dut.gencon_inst.key_read), 32'd1);
    lows = 0;
    repeat (hold_cycles) begin
      @(negedge clk);
      if (!dut.gencon_inst.key_read) lows++;
    end
    if (hold_cycles > 10) check("hold_key_read_low_cycles", 32'(lows), 32'd0);
    pressing = 1'b0;
    n = 0;
    while (dut.input_ctrl_inst.state != 0 && n < 50) begin
      @(negedge clk); n++;
    end
    @(negedge clk);
    check("key_read_clear", 32'(dut.gencon_inst.key_read), 32'd0);
    model_key(k);
    check($sformatf("disp_k%0d", k), 32'(display_output), 32'(m_disp));
    check($sformatf("comp_k%0d", k), 32'(complete), 32'(m_comp));
  endtask

  task automatic run_seq(input int keys[$]);
    foreach (keys[i]) press(keys[i], 3);
  endtask

  int r;
  int k;

  initial begin
    model_reset();
    nRST = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col", 32'(ColOut), 32'hE);
    check("rst_disp", 32'(display_output), 32'd0);
    check("rst_comp", 32'(complete), 32'd0);
    check("rst_state", 32'(dut.input_ctrl_inst.state), 32'd0);
    check("rst_key_read", 32'(dut.gencon_inst.key_read), 32'd0);
    nRST = 1'b1;
    repeat (15) @(negedge clk);
    check("scan_hold_col0", 32'(ColOut), 32'hE);
    @(negedge clk);
    check("scan_col1", 32'(ColOut), 32'hD);
    repeat (16) @(negedge clk);
    check("scan_col2", 32'(ColOut), 32'hB);

    run_seq('{2, 11, 4, 12});
    check("mul_3x4", 32'(display_output), 32'd12);
    press(2, 3);
    check("digit_clears_complete", 32'(complete), 32'd0);
    run_seq('{3, 4, 12});
    check("add_3p4", 32'(display_output), 32'd7);
    run_seq('{8, 7, 5, 12});
    check("sub_7m5", 32'(display_output), 32'd2);
    run_seq('{2, 7, 9, 12, 12});
    check("sub_neg", 32'(display_output), 32'hFFFB);

    // Single-cycle glitch must not yield a key.
    @(negedge clk);
    glitch = 1'b1;
    @(negedge clk);
    glitch = 1'b0;
    check("glitch_detect", 32'(dut.input_ctrl_inst.state), 32'd1);
    @(negedge clk);
    check("glitch_abort", 32'(dut.input_ctrl_inst.state), 32'd0);
    check("glitch_no_read", 32'(dut.gencon_inst.key_read), 32'd0);
    check("glitch_disp", 32'(display_output), 32'(m_disp));

    press(14, 3);
    press(5, 300);
    check("long_hold_single", 32'(display_output), 32'd5);

    run_seq('{14, 0, 13, 13, 13, 13, 11, 0, 13, 13, 13, 13, 12});
    check("mul_wrap", 32'(display_output), 32'hE100);
    run_seq('{2, 3, 5, 14});
    check("clear_disp", 32'(display_output), 32'd0);
    run_seq('{15, 6, 15, 2, 12});

    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55) begin
        k = $urandom_range(0, 9);
        k = (k == 9) ? 13 : (k / 3) * 4 + (k % 3);
      end else if (r < 80) begin
        k = $urandom_range(0, 3) * 4 + 3;
      end else if (r < 95) k = 12;
      else k = 14;
      press(k, $urandom_range(2, 6));
    end

    // Asynchronous reset mid-entry.
    run_seq('{4, 5, 3, 6});
    #3 nRST = 1'b0;
    #1;
    model_reset();
    check("async_rst_disp", 32'(display_output), 32'd0);
    check("async_rst_comp", 32'(complete), 32'd0);
    check("async_rst_col", 32'(ColOut), 32'hE);
    @(negedge clk);
    nRST = 1'b1;
    run_seq('{1, 12});
    check("post_rst", 32'(display_output), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
